// File: rtl/rtc_counter_pkg.sv
// Shared constants for the BCD real-time-clock counter.
//   - BCD field limits used by the increment cascade.
//   - Reset values for the time fields.
package rtc_counter_pkg;

    // Inclusive BCD upper limits and the day restart value.
    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] DAY_MAX  = 8'h31;
    localparam logic [7:0] DAY_MIN  = 8'h01;

    // Reset values.
    localparam logic [7:0] SEC_RST  = 8'h00;
    localparam logic [7:0] MIN_RST  = 8'h00;
    localparam logic [7:0] HOUR_RST = 8'h00;
    localparam logic [7:0] DAY_RST  = 8'h01;

endpackage

// File: rtl/rtc_counter_bcd_field_inc.sv
// Combinational 8-bit BCD field increment with saturating wrap.
//   en    : advance this field
//   val   : current BCD value
//   nxt   : next BCD value (equals val when en=0)
//   carry : field wrapped, advance the next field
module bcd_field_inc #(
    parameter logic [7:0] MAX = 8'h59,
    parameter logic [7:0] MIN = 8'h00
) (
    input  logic       en,
    input  logic [7:0] val,
    output logic [7:0] nxt,
    output logic       carry
);

    always_comb begin
        nxt   = val;
        carry = 1'b0;
        if (en) begin
            // Anything at or above the limit (including illegal loads) restarts.
            if (val >= MAX) begin
                nxt   = MIN;
                carry = 1'b1;
            end else if (val[3:0] >= 4'd9) begin
                // Illegal unit digits behave as 9 and carry into tens.
                nxt = {val[7:4] + 4'd1, 4'd0};
            end else begin
                nxt = {val[7:4], val[3:0] + 4'd1};
            end
        end
    end

endmodule

// File: rtl/rtc_counter.sv
// Free-running BCD time-of-day / day-of-month counter.
//   CLK1K, RSTN          : clock and async active-low reset
//   SW1                  : 1 = load *_SET every edge, 0 = run
//   SEC/MIN/HOUR/DAY_SET : BCD values to load in set mode
//   SEC/MIN/HOUR/DAY     : registered current BCD time
//   SEC_TICK             : one-cycle pulse with each 1 s advance
//   DAY_WRAP             : one-cycle pulse when DAY wraps 31 -> 01
module rtc_counter
    import rtc_counter_pkg::*;
#(
    parameter int unsigned CLK_HZ = 1000
) (
    input  logic       CLK1K,
    input  logic       RSTN,
    input  logic       SW1,
    input  logic [7:0] SEC_SET,
    input  logic [7:0] MIN_SET,
    input  logic [7:0] HOUR_SET,
    input  logic [7:0] DAY_SET,
    output logic [7:0] SEC,
    output logic [7:0] MIN,
    output logic [7:0] HOUR,
    output logic [7:0] DAY,
    output logic       SEC_TICK,
    output logic       DAY_WRAP
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [7:0]    sec_q, sec_d, min_q, min_d, hour_q, hour_d, day_q, day_d;
    logic          sec_tick_q, sec_tick_d, day_wrap_q, day_wrap_d;

    logic          tick;
    logic [7:0]    sec_nxt, min_nxt, hour_nxt, day_nxt;
    logic          sec_c, min_c, hour_c, day_c;

    // Set mode suppresses the tick even when the prescaler sits at its last count.
    assign tick = !SW1 && (presc_q == PRESC_LAST);

    bcd_field_inc #(.MAX(SEC_MAX), .MIN(8'h00)) u_sec_inc (
        .en(tick), .val(sec_q), .nxt(sec_nxt), .carry(sec_c)
    );
    bcd_field_inc #(.MAX(MIN_MAX), .MIN(8'h00)) u_min_inc (
        .en(sec_c), .val(min_q), .nxt(min_nxt), .carry(min_c)
    );
    bcd_field_inc #(.MAX(HOUR_MAX), .MIN(8'h00)) u_hour_inc (
        .en(min_c), .val(hour_q), .nxt(hour_nxt), .carry(hour_c)
    );
    bcd_field_inc #(.MAX(DAY_MAX), .MIN(DAY_MIN)) u_day_inc (
        .en(hour_c), .val(day_q), .nxt(day_nxt), .carry(day_c)
    );

    always_comb begin
        presc_d    = presc_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        day_d      = day_q;
        sec_tick_d = 1'b0;
        day_wrap_d = 1'b0;
        if (SW1) begin
            presc_d = '0;
            sec_d   = SEC_SET;
            min_d   = MIN_SET;
            hour_d  = HOUR_SET;
            day_d   = DAY_SET;
        end else begin
            presc_d    = tick ? '0 : presc_q + PW'(1);
            sec_d      = sec_nxt;
            min_d      = min_nxt;
            hour_d     = hour_nxt;
            day_d      = day_nxt;
            sec_tick_d = tick;
            day_wrap_d = day_c;
        end
    end

    always_ff @(posedge CLK1K or negedge RSTN) begin
        if (!RSTN) begin
            presc_q    <= '0;
            sec_q      <= SEC_RST;
            min_q      <= MIN_RST;
            hour_q     <= HOUR_RST;
            day_q      <= DAY_RST;
            sec_tick_q <= 1'b0;
            day_wrap_q <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            day_q      <= day_d;
            sec_tick_q <= sec_tick_d;
            day_wrap_q <= day_wrap_d;
        end
    end

    assign SEC      = sec_q;
    assign MIN      = min_q;
    assign HOUR     = hour_q;
    assign DAY      = day_q;
    assign SEC_TICK = sec_tick_q;
    assign DAY_WRAP = day_wrap_q;

endmodule

// File: tb/tb_rtc_counter.sv
// Self-checking bench for rtc_counter: behavioural time model checked every
// cycle plus directed scenarios with literal expectations.
module tb_rtc_counter;

    localparam int unsigned HZ = 8;

    logic       CLK1K = 1'b0;
    logic       RSTN  = 1'b0;
    logic       SW1   = 1'b0;
    logic [7:0] SEC_SET = 8'h00, MIN_SET = 8'h00, HOUR_SET = 8'h00, DAY_SET = 8'h01;
    logic [7:0] SEC, MIN, HOUR, DAY;
    logic       SEC_TICK, DAY_WRAP;

    rtc_counter #(.CLK_HZ(HZ)) dut (
        .CLK1K(CLK1K), .RSTN(RSTN), .SW1(SW1),
        .SEC_SET(SEC_SET), .MIN_SET(MIN_SET), .HOUR_SET(HOUR_SET), .DAY_SET(DAY_SET),
        .SEC(SEC), .MIN(MIN), .HOUR(HOUR), .DAY(DAY),
        .SEC_TICK(SEC_TICK), .DAY_WRAP(DAY_WRAP)
    );

    always #5 CLK1K = ~CLK1K;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_sec = 8'h00, m_min = 8'h00, m_hour = 8'h00, m_day = 8'h01;
    bit         m_tick = 0, m_wrap = 0;
    int         m_presc = 0;

    // Decimal-arithmetic BCD step: limit or above restarts, else value+1.
    function automatic logic [7:0] step(input logic [7:0] v, input logic [7:0] mx,
                                        input logic [7:0] mn, output bit c);
        int tens, units, n;
        c = 0;
        if (v >= mx) begin
            c = 1;
            return mn;
        end
        tens  = int'(v[7:4]);
        units = int'(v[3:0]);
        if (units > 9) units = 9;
        n = tens * 10 + units + 1;
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    always @(posedge CLK1K or negedge RSTN) begin
        bit c0, c1, c2, c3;
        if (!RSTN) begin
            m_sec = 8'h00; m_min = 8'h00; m_hour = 8'h00; m_day = 8'h01;
            m_tick = 0; m_wrap = 0; m_presc = 0;
        end else if (SW1) begin
            m_sec = SEC_SET; m_min = MIN_SET; m_hour = HOUR_SET; m_day = DAY_SET;
            m_tick = 0; m_wrap = 0; m_presc = 0;
        end else begin
            m_tick  = (m_presc == HZ - 1);
            m_presc = m_tick ? 0 : m_presc + 1;
            m_wrap  = 0;
            if (m_tick) begin
                m_sec = step(m_sec, 8'h59, 8'h00, c0);
                if (c0) m_min = step(m_min, 8'h59, 8'h00, c1); else c1 = 0;
                if (c1) m_hour = step(m_hour, 8'h23, 8'h00, c2); else c2 = 0;
                if (c2) m_day = step(m_day, 8'h31, 8'h01, c3); else c3 = 0;
                m_wrap = c3;
            end
        end
    end

    // Every-cycle comparison against the model.
    bit cmp_en = 0;
    always @(negedge CLK1K) begin
        if (cmp_en) begin
            check("model SEC", {24'd0, SEC}, {24'd0, m_sec});
            check("model MIN", {24'd0, MIN}, {24'd0, m_min});
            check("model HOUR", {24'd0, HOUR}, {24'd0, m_hour});
            check("model DAY", {24'd0, DAY}, {24'd0, m_day});
            check("model SEC_TICK", {31'd0, SEC_TICK}, {31'd0, m_tick});
            check("model DAY_WRAP", {31'd0, DAY_WRAP}, {31'd0, m_wrap});
        end
    end

    // ---------------- directed helpers ----------------
    // Count negedges until SEC_TICK is seen; bounded.
    task automatic wait_tick(input string name, input int exp_n);
        int n = 0;
        do begin
            @(negedge CLK1K);
            n++;
        end while (!SEC_TICK && n < 4 * HZ);
        check(name, n, exp_n);
    endtask

    task automatic expect_time(input string name, input logic [7:0] s, input logic [7:0] m,
                               input logic [7:0] h, input logic [7:0] d);
        check({name, " SEC"}, {24'd0, SEC}, {24'd0, s});
        check({name, " MIN"}, {24'd0, MIN}, {24'd0, m});
        check({name, " HOUR"}, {24'd0, HOUR}, {24'd0, h});
        check({name, " DAY"}, {24'd0, DAY}, {24'd0, d});
    endtask

    // Called at a negedge: one set-mode edge, then back to run mode.
    task automatic load(input logic [7:0] s, input logic [7:0] m, input logic [7:0] h,
                        input logic [7:0] d);
        SW1 = 1'b1; SEC_SET = s; MIN_SET = m; HOUR_SET = h; DAY_SET = d;
        @(negedge CLK1K);
        expect_time("load", s, m, h, d);
        SW1 = 1'b0;
    endtask

    initial begin
        // Reset state.
        repeat (3) @(negedge CLK1K);
        expect_time("reset", 8'h00, 8'h00, 8'h00, 8'h01);
        check("reset SEC_TICK", {31'd0, SEC_TICK}, 32'd0);
        check("reset DAY_WRAP", {31'd0, DAY_WRAP}, 32'd0);
        RSTN = 1'b1;
        cmp_en = 1;

        // Tick spacing from 00:00:00.
        wait_tick("first tick latency", HZ);
        wait_tick("tick spacing 2", HZ);
        wait_tick("tick spacing 3", HZ);
        expect_time("after 3 s", 8'h03, 8'h00, 8'h00, 8'h01);

        // Reset mid-count is immediate.
        repeat (3) @(negedge CLK1K);
        #2 RSTN = 1'b0;
        #1 expect_time("async reset", 8'h00, 8'h00, 8'h00, 8'h01);
        @(negedge CLK1K);
        RSTN = 1'b1;
        wait_tick("tick after reset", HZ);
        expect_time("1 s after reset", 8'h01, 8'h00, 8'h00, 8'h01);

        // Load and run through the day wrap.
        @(negedge CLK1K);
        load(8'h58, 8'h59, 8'h23, 8'h31);
        wait_tick("tick after load", HZ);
        expect_time("58->59", 8'h59, 8'h59, 8'h23, 8'h31);
        wait_tick("tick to wrap", HZ);
        expect_time("day wrap", 8'h00, 8'h00, 8'h00, 8'h01);
        check("DAY_WRAP pulse", {31'd0, DAY_WRAP}, 32'd1);
        @(negedge CLK1K);
        check("DAY_WRAP one cycle", {31'd0, DAY_WRAP}, 32'd0);

        // Set mode raised in the tick cycle wins.
        for (int i = 0; i < 2 * HZ && m_presc != HZ - 1; i++) @(negedge CLK1K);
        check("found tick cycle", m_presc, HZ - 1);
        SW1 = 1'b1; SEC_SET = 8'h12; MIN_SET = 8'h34; HOUR_SET = 8'h05; DAY_SET = 8'h07;
        @(negedge CLK1K);
        check("set in tick SEC_TICK", {31'd0, SEC_TICK}, 32'd0);
        expect_time("set in tick", 8'h12, 8'h34, 8'h05, 8'h07);
        SW1 = 1'b0;

        // Illegal loads.
        load(8'h5A, 8'h10, 8'h00, 8'h00);
        wait_tick("tick illegal sec", HZ);
        expect_time("5A wraps", 8'h00, 8'h11, 8'h00, 8'h00);
        load(8'h59, 8'h59, 8'h23, 8'h00);
        wait_tick("tick day 00", HZ);
        expect_time("day 00 -> 01", 8'h00, 8'h00, 8'h00, 8'h01);
        check("no wrap from 00", {31'd0, DAY_WRAP}, 32'd0);

        // Closed loop: set session re-loading the published time.
        load(8'h56, 8'h34, 8'h12, 8'h15);
        wait_tick("loop tick 1", HZ);
        wait_tick("loop tick 2", HZ);
        expect_time("12:34:58", 8'h58, 8'h34, 8'h12, 8'h15);
        repeat (3) @(negedge CLK1K);
        SW1 = 1'b1; SEC_SET = 8'h58; MIN_SET = 8'h34; HOUR_SET = 8'h12; DAY_SET = 8'h15;
        repeat (2) @(negedge CLK1K);
        expect_time("frozen during set", 8'h58, 8'h34, 8'h12, 8'h15);
        SW1 = 1'b0;
        wait_tick("loop resume tick", HZ);
        expect_time("12:34:59", 8'h59, 8'h34, 8'h12, 8'h15);
        wait_tick("loop tick min", HZ);
        expect_time("12:35:00", 8'h00, 8'h35, 8'h12, 8'h15);

        @(negedge CLK1K);
        cmp_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
